// File: rtl/gen_fifo_ext.sv
// Synchronous FIFO with any integer depth, selectable registered or first-word-fall-through
// read, programmable full/almost-empty thresholds and sticky overflow/underflow flags.
module gen_fifo_ext #(
  parameter int unsigned W          = 8,
  parameter int unsigned D          = 4,
  parameter bit          WR_ON_FULL = 1'b0,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned CNT_W      = $clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] full_thr,
  input  logic [CNT_W-1:0] empty_thr,
  output logic [CNT_W-1:0] used_space,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  output logic             wr_full,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             rd_empty,
  output logic             rd_aempty,
  input  logic             err_clr,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned      PtrW     = (D > 1) ? $clog2(D) : 1;
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(D - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(D);

  logic [W-1:0]     mem_q [D];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] used_q, used_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_int, empty_int, rd_int, wr_int;

  // Requests presented during a clear are ignored outright, so they can neither move state
  // nor raise an error flag.
  always_comb begin
    full_int  = (used_q == DepthCnt);
    empty_int = (used_q == '0);
    rd_int    = rd_en & ~empty_int & ~clear;
    wr_int    = wr_en & ~clear & (~full_int | (WR_ON_FULL & rd_int));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end else begin
      if (wr_int) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_int) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({wr_int, rd_int})
        2'b10:   used_d = used_q + CNT_W'(1);
        2'b01:   used_d = used_q - CNT_W'(1);
        default: used_d = used_q;
      endcase
    end

    // A fresh error in the err_clr cycle wins over the clear.
    ovf_d = (ovf_q & ~err_clr) | (wr_en & ~clear & ~wr_int);
    udf_d = (udf_q & ~err_clr) | (rd_en & ~clear & empty_int);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_int) mem_q[wr_ptr_q] <= wr_data;
  end

  if (FWFT) begin : g_fwft
    assign rd_data = empty_int ? '0 : mem_q[rd_ptr_q];
  end else begin : g_reg
    logic [W-1:0] rd_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (rd_int) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
    assign rd_data = rd_data_q;
  end

  assign used_space = used_q;
  assign rd_empty   = empty_int;
  assign rd_aempty  = (used_q <= empty_thr);
  assign wr_full    = ((DepthCnt - used_q) <= full_thr);
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_gen_fifo_ext.sv
// Drives four FIFO variants (D=5/4, FWFT on/off, WR_ON_FULL on/off) with shared stimulus and
// compares each against a queue-based model of the FIFO's documented behaviour.
module tb_gen_fifo_ext;

  localparam int NI = 4;

  logic       clk;
  logic       rst, clear, wr_en, rd_en, err_clr;
  logic [2:0] full_thr, empty_thr;
  logic [7:0] wr_data;

  logic [2:0] used_a      [NI];
  logic [7:0] rd_data_a   [NI];
  logic       wr_full_a   [NI];
  logic       rd_empty_a  [NI];
  logic       rd_aempty_a [NI];
  logic       ovf_a       [NI];
  logic       udf_a       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gen_fifo_ext #(
      .W         (8),
      .D         ((g < 2) ? 5 : 4),
      .WR_ON_FULL((g == 1) || (g == 2)),
      .FWFT      ((g % 2) == 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .full_thr  (full_thr),
      .empty_thr (empty_thr),
      .used_space(used_a[g]),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_full   (wr_full_a[g]),
      .rd_en     (rd_en),
      .rd_data   (rd_data_a[g]),
      .rd_empty  (rd_empty_a[g]),
      .rd_aempty (rd_aempty_a[g]),
      .err_clr   (err_clr),
      .ovf       (ovf_a[g]),
      .udf       (udf_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance configuration, contents queue, registered read word, flags.
  int         md [NI] = '{5, 5, 4, 4};
  bit         mf [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit         mw [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] mq [NI][$];
  logic [7:0] mrd [NI];
  bit         movf [NI];
  bit         mudf [NI];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void model_step();
    for (int k = 0; k < NI; k++) begin
      int         sz;
      bit         rok, wok, nov, nud;
      logic [7:0] v;
      sz  = mq[k].size();
      rok = 1'b0;
      wok = 1'b0;
      nov = 1'b0;
      nud = 1'b0;
      if (rst) begin
        mq[k].delete();
        mrd[k]  = 8'h00;
        movf[k] = 1'b0;
        mudf[k] = 1'b0;
      end else begin
        if (clear) begin
          mq[k].delete();
        end else begin
          rok = rd_en && (sz > 0);
          wok = wr_en && ((sz < md[k]) || (mw[k] && rok));
          nov = wr_en && !wok;
          nud = rd_en && !rok;
          if (rok) begin
            v = mq[k].pop_front();
            if (!mf[k]) mrd[k] = v;
          end
          if (wok) mq[k].push_back(wr_data);
        end
        movf[k] = (movf[k] && !err_clr) || nov;
        mudf[k] = (mudf[k] && !err_clr) || nud;
      end
    end
  endfunction

  function automatic logic [7:0] exp_rd(int k);
    if (mf[k]) return (mq[k].size() > 0) ? mq[k][0] : 8'h00;
    return mrd[k];
  endfunction

  function automatic logic [2:0] exp_used(int k);
    return 3'(mq[k].size());
  endfunction

  function automatic logic exp_full(int k);
    return (md[k] - mq[k].size()) <= int'(full_thr);
  endfunction

  function automatic logic exp_aempty(int k);
    return mq[k].size() <= int'(empty_thr);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 0; clear = 0; wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; wr_en = 1; rd_en = 1; clear = 1; wr_data = 8'hEE;
    full_thr = 3'd0; empty_thr = 3'd0;
    tick();
    idle();
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (used_a[k] !== 3'd0) $display("FAIL reset_used inst%0d: got %0d want 0", k, used_a[k]); else n_pass++;
      n_chk++; if (rd_empty_a[k] !== 1'b1) $display("FAIL reset_empty inst%0d: got %b want 1", k, rd_empty_a[k]); else n_pass++;
      n_chk++; if (rd_aempty_a[k] !== 1'b1) $display("FAIL reset_aempty inst%0d: got %b want 1", k, rd_aempty_a[k]); else n_pass++;
      n_chk++; if (wr_full_a[k] !== 1'b0) $display("FAIL reset_full inst%0d: got %b want 0", k, wr_full_a[k]); else n_pass++;
      n_chk++; if (rd_data_a[k] !== 8'h00) $display("FAIL reset_rdata inst%0d: got %h want 00", k, rd_data_a[k]); else n_pass++;
      n_chk++; if ({ovf_a[k], udf_a[k]} !== 2'b00) $display("FAIL reset_err inst%0d: got %b want 00", k, {ovf_a[k], udf_a[k]}); else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    idle();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1; wr_data = 8'(i * 17);
      tick();
      for (int k = 0; k < NI; k++) begin
        n_chk++; if (used_a[k] !== exp_used(k)) $display("FAIL fill_used inst%0d: got %0d want %0d", k, used_a[k], exp_used(k)); else n_pass++;
        n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL fill_rdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
      end
    end
    wr_en = 0;
    n_chk++; if (used_a[0] !== 3'd5) $display("FAIL fill_full5: got %0d want 5", used_a[0]); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      rd_en = 1;
      tick();
      n_chk++; if (rd_data_a[0] !== 8'(i * 17)) $display("FAIL drain_seq: got %h want %h", rd_data_a[0], 8'(i * 17)); else n_pass++;
      n_chk++; if (used_a[0] !== 3'(5 - i)) $display("FAIL drain_used: got %0d want %0d", used_a[0], 5 - i); else n_pass++;
      for (int k = 0; k < NI; k++) begin
        n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL drain_rdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
        n_chk++; if (udf_a[k] !== mudf[k]) $display("FAIL drain_udf inst%0d: got %b want %b", k, udf_a[k], mudf[k]); else n_pass++;
        n_chk++; if (ovf_a[k] !== movf[k]) $display("FAIL fill_ovf inst%0d: got %b want %b", k, ovf_a[k], movf[k]); else n_pass++;
      end
    end
    rd_en = 0;
    tick();
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (rd_empty_a[k] !== 1'b1) $display("FAIL drain_empty inst%0d: got %b want 1", k, rd_empty_a[k]); else n_pass++;
    end
  endtask

  task automatic test_fwft();
    idle();
    err_clr = 1;
    tick();
    err_clr = 0; wr_en = 1; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (rd_empty_a[k] !== 1'b0) $display("FAIL fwft_empty inst%0d: got %b want 0", k, rd_empty_a[k]); else n_pass++;
      n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL fwft_rdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
    end
    n_chk++; if (rd_data_a[1] !== 8'hA5) $display("FAIL fwft_show: got %h want a5", rd_data_a[1]); else n_pass++;
    rd_en = 1;
    tick();
    rd_en = 0;
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (rd_empty_a[k] !== 1'b1) $display("FAIL fwft_pop inst%0d: got %b want 1", k, rd_empty_a[k]); else n_pass++;
      n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL fwft_popdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
    end
  endtask

  task automatic test_thresholds();
    idle();
    full_thr = 3'd1; empty_thr = 3'd1;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i <= 3; i++) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        n_chk++; if (wr_full_a[k] !== exp_full(k)) $display("FAIL thr_full inst%0d used%0d: got %b want %b", k, i, wr_full_a[k], exp_full(k)); else n_pass++;
        n_chk++; if (rd_aempty_a[k] !== exp_aempty(k)) $display("FAIL thr_aempty inst%0d used%0d: got %b want %b", k, i, rd_aempty_a[k], exp_aempty(k)); else n_pass++;
      end
      if (i < 3) begin
        wr_en = 1; wr_data = 8'(i);
        tick();
        wr_en = 0;
      end
    end
    n_chk++; if (wr_full_a[2] !== 1'b1) $display("FAIL thr_d4_full3: got %b want 1", wr_full_a[2]); else n_pass++;
    full_thr = 3'd7;
    #1;
    n_chk++; if (wr_full_a[0] !== 1'b1) $display("FAIL thr_big: got %b want 1", wr_full_a[0]); else n_pass++;
  endtask

  task automatic test_wr_on_full();
    idle();
    full_thr = 3'd0; empty_thr = 3'd0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr_en = 1; rd_en = 1; wr_data = 8'hCF;
    tick();
    idle();
    n_chk++; if ({used_a[2], ovf_a[2]} !== {3'd4, 1'b0}) $display("FAIL wof1 d4: got used %0d ovf %b want 4 0", used_a[2], ovf_a[2]); else n_pass++;
    n_chk++; if ({used_a[3], ovf_a[3]} !== {3'd3, 1'b1}) $display("FAIL wof0 d4: got used %0d ovf %b want 3 1", used_a[3], ovf_a[3]); else n_pass++;
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (used_a[k] !== exp_used(k)) $display("FAIL wof_used inst%0d: got %0d want %0d", k, used_a[k], exp_used(k)); else n_pass++;
      n_chk++; if (ovf_a[k] !== movf[k]) $display("FAIL wof_ovf inst%0d: got %b want %b", k, ovf_a[k], movf[k]); else n_pass++;
      n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL wof_rdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
    end
  endtask

  task automatic test_errors();
    idle();
    rst = 1;
    tick();
    rst = 0; rd_en = 1;
    tick();
    n_chk++; if ({udf_a[0], used_a[0]} !== {1'b1, 3'd0}) $display("FAIL udf_set: got %b/%0d want 1/0", udf_a[0], used_a[0]); else n_pass++;
    err_clr = 1;
    tick();
    n_chk++; if (udf_a[0] !== 1'b1) $display("FAIL udf_wins: got %b want 1", udf_a[0]); else n_pass++;
    rd_en = 0;
    tick();
    err_clr = 0;
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (udf_a[k] !== 1'b0) $display("FAIL udf_clr inst%0d: got %b want 0", k, udf_a[k]); else n_pass++;
    end
  endtask

  task automatic test_clear();
    idle();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = 8'(8'h70 + i);
      tick();
    end
    clear = 1; wr_en = 1; rd_en = 1;
    tick();
    idle();
    for (int k = 0; k < NI; k++) begin
      n_chk++; if (used_a[k] !== 3'd0) $display("FAIL clr_used inst%0d: got %0d want 0", k, used_a[k]); else n_pass++;
      n_chk++; if (rd_empty_a[k] !== 1'b1) $display("FAIL clr_empty inst%0d: got %b want 1", k, rd_empty_a[k]); else n_pass++;
      n_chk++; if ({ovf_a[k], udf_a[k]} !== 2'b00) $display("FAIL clr_err inst%0d: got %b want 00", k, {ovf_a[k], udf_a[k]}); else n_pass++;
      n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL clr_rdata inst%0d: got %h want %h", k, rd_data_a[k], exp_rd(k)); else n_pass++;
    end
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; rd_en = (i % 2 == 1); wr_data = 8'(8'h90 + i);
      tick();
    end
    rst = 1;
    tick();
    idle();
    for (int k = 0; k < NI; k++) begin
      n_chk++; if ({used_a[k], rd_empty_a[k], rd_aempty_a[k], rd_data_a[k], ovf_a[k], udf_a[k]} !==
                   {3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0})
        $display("FAIL midrst inst%0d: got used %0d empty %b aempty %b rdata %h ovf %b udf %b",
                 k, used_a[k], rd_empty_a[k], rd_aempty_a[k], rd_data_a[k], ovf_a[k], udf_a[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      clear     = ($urandom_range(0, 99) < 4);
      err_clr   = ($urandom_range(0, 99) < 8);
      wr_en     = ($urandom_range(0, 99) < 55);
      rd_en     = ($urandom_range(0, 99) < 50);
      wr_data   = 8'($urandom);
      full_thr  = 3'($urandom_range(0, 6));
      empty_thr = 3'($urandom_range(0, 6));
      tick();
      for (int k = 0; k < NI; k++) begin
        n_chk++; if (used_a[k] !== exp_used(k)) $display("FAIL rnd_used c%0d inst%0d: got %0d want %0d", c, k, used_a[k], exp_used(k)); else n_pass++;
        n_chk++; if (rd_data_a[k] !== exp_rd(k)) $display("FAIL rnd_rdata c%0d inst%0d: got %h want %h", c, k, rd_data_a[k], exp_rd(k)); else n_pass++;
        n_chk++; if (rd_empty_a[k] !== (mq[k].size() == 0)) $display("FAIL rnd_empty c%0d inst%0d: got %b", c, k, rd_empty_a[k]); else n_pass++;
        n_chk++; if (wr_full_a[k] !== exp_full(k)) $display("FAIL rnd_full c%0d inst%0d: got %b want %b", c, k, wr_full_a[k], exp_full(k)); else n_pass++;
        n_chk++; if (rd_aempty_a[k] !== exp_aempty(k)) $display("FAIL rnd_aempty c%0d inst%0d: got %b want %b", c, k, rd_aempty_a[k], exp_aempty(k)); else n_pass++;
        n_chk++; if (ovf_a[k] !== movf[k]) $display("FAIL rnd_ovf c%0d inst%0d: got %b want %b", c, k, ovf_a[k], movf[k]); else n_pass++;
        n_chk++; if (udf_a[k] !== mudf[k]) $display("FAIL rnd_udf c%0d inst%0d: got %b want %b", c, k, udf_a[k], mudf[k]); else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    rst = 1; clear = 0; wr_en = 0; rd_en = 0; err_clr = 0;
    wr_data = 8'h00; full_thr = 3'd0; empty_thr = 3'd0;
    test_reset();
    test_fill_drain();
    test_fwft();
    test_thresholds();
    test_wr_on_full();
    test_errors();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
